mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter sharing the single Avalon-style memory port (`bus_memory`) between the CPU instruction-fetch unit (master 0) and the load/store unit (master 1). Each master sees a private read/write/waitrequest interface; the arbiter grants one whole transaction at a time, steers address, data and byteenable to the slave, and routes `waitrequest` back. A watchdog flags and aborts transactions the slave never completes.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 15 +
 rtl/mem_bus_arbiter_watchdog.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory-bus arbiter: FSM state encoding, Avalon master request, boot vector.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } avm_req_t;

    localparam logic [31:0] MEM_RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One Avalon-style memory port; "master" is the requester's view, "slave" the responder's view.
interface mem_bus_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, byteenable,
                    input  waitrequest, readdata);
    modport slave  (input  address, read, write, writedata, byteenable,
                    output waitrequest, readdata);
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Per-transaction slave-stall counter with a sticky timeout flag cleared only by reset.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expire,
    output logic timeout_error
);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt;

    // Fires on the last tolerated stall cycle, so the counter never needs to saturate.
    assign expire = stall && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            timeout_error <= 1'b0;
        end else begin
            if (clear)
                cnt <= '0;
            else if (stall)
                cnt <= cnt + 8'd1;
            if (expire)
                timeout_error <= 1'b1;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave Avalon arbiter granting whole transactions, with a stall watchdog.
// Define MEM_BUS_ARBITER_RR_EN for round-robin ties; default is fixed priority to m1.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  m0,
    mem_bus_arbiter_if.slave  m1,
    mem_bus_arbiter_if.master s,
    output logic [1:0]        grant,
    output logic              timeout_error
);
    arb_state_t state, state_nxt;
    logic       last_grant, last_grant_nxt;   // 0 = m0, 1 = m1
    avm_req_t   req0, req1, sel;
    logic       r0, r1, own_req, stall, expire, tie_m1;

    assign req0 = {m0.address, m0.read, m0.write, m0.writedata, m0.byteenable};
    assign req1 = {m1.address, m1.read, m1.write, m1.writedata, m1.byteenable};
    assign r0   = m0.read | m0.write;
    assign r1   = m1.read | m1.write;

`ifdef MEM_BUS_ARBITER_RR_EN
    assign tie_m1 = ~last_grant;
`else
    assign tie_m1 = 1'b1;
`endif

    assign own_req = ((state == ARB_GRANT0) && r0) || ((state == ARB_GRANT1) && r1);
    assign stall   = own_req && s.waitrequest;

    arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk           (clk),
        .reset         (reset),
        .clear         (state == ARB_IDLE),
        .stall         (stall),
        .expire        (expire),
        .timeout_error (timeout_error)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        sel            = '0;
        grant          = 2'b00;
        m0.waitrequest = 1'b1;
        m0.readdata    = '0;
        m1.waitrequest = 1'b1;
        m1.readdata    = '0;
        case (state)
            ARB_IDLE: begin
                if (r0 && r1)
                    state_nxt = tie_m1 ? ARB_GRANT1 : ARB_GRANT0;
                else if (r0)
                    state_nxt = ARB_GRANT0;
                else if (r1)
                    state_nxt = ARB_GRANT1;
            end
            ARB_GRANT0: begin
                sel            = req0;
                grant          = 2'b01;
                m0.waitrequest = s.waitrequest;
                m0.readdata    = s.readdata;
            end
            ARB_GRANT1: begin
                sel            = req1;
                grant          = 2'b10;
                m1.waitrequest = s.waitrequest;
                m1.readdata    = s.readdata;
            end
            default: state_nxt = ARB_IDLE;
        endcase
        // A dropped request abandons the grant without touching the fairness history.
        if (state != ARB_IDLE) begin
            if (!own_req) begin
                state_nxt = ARB_IDLE;
            end else if (!s.waitrequest || expire) begin
                state_nxt      = ARB_IDLE;
                last_grant_nxt = (state == ARB_GRANT1);
            end
        end
    end

    assign s.address    = sel.address;
    assign s.read       = sel.read;
    assign s.write      = sel.write & ~sel.read;
    assign s.writedata  = sel.writedata;
    assign s.byteenable = sel.byteenable;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of single transactions, concurrent
// arbitration sequences, watchdog abort and mid-transaction reset.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 4;

    typedef struct {
        int          m;
        bit          wr;
        bit          both;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          stall;
        logic [31:0] exp;
    } op_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;
    logic       timeout_error;

    mem_bus_arbiter_if m0();
    mem_bus_arbiter_if m1();
    mem_bus_arbiter_if s();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .m0            (m0),
        .m1            (m1),
        .s             (s),
        .grant         (grant),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;

    // Slave model: word memory, programmable stall count per transaction.
    logic [31:0] mem [16];
    int          scnt;
    int          stall_cfg = 0;
    bit          stall_forever = 1'b0;

    always_comb begin
        s.waitrequest = (s.read || s.write) && (stall_forever || scnt < stall_cfg);
        s.readdata    = (s.read && !s.waitrequest) ? mem[s.address[5:2]] : 32'h0;
    end

    always @(posedge clk) begin
        if (reset || !(s.read || s.write) || !s.waitrequest) scnt <= 0;
        else scnt <= scnt + 1;
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h10000000 | i;
        end else if (s.write && !s.waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (s.byteenable[b]) mem[s.address[5:2]][8*b +: 8] <= s.writedata[8*b +: 8];
        end
    end

    // Completion monitor: owner and cycle of each finished transaction.
    int cyc = 0;
    int gq[$];
    int gcyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!reset) begin
            if (grant == 2'b01 && !m0.waitrequest && (m0.read || m0.write)) begin
                gq.push_back(0); gcyc.push_back(cyc);
            end
            if (grant == 2'b10 && !m1.waitrequest && (m1.read || m1.write)) begin
                gq.push_back(1); gcyc.push_back(cyc);
            end
        end
    end

    int          passed = 0;
    int          total = 0;
    logic [31:0] sb [2][$];
    op_t         opq [2][$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic wreq(input int m);
        return (m == 0) ? m0.waitrequest : m1.waitrequest;
    endfunction

    function automatic logic [31:0] rdata(input int m);
        return (m == 0) ? m0.readdata : m1.readdata;
    endfunction

    task automatic drive(input int m, input op_t op, input bit en);
        logic rd, wr;
        rd = en && (!op.wr || op.both);
        wr = en && (op.wr || op.both);
        if (m == 0) begin
            m0.address = op.addr; m0.read = rd; m0.write = wr;
            m0.writedata = op.data; m0.byteenable = op.be;
        end else begin
            m1.address = op.addr; m1.read = rd; m1.write = wr;
            m1.writedata = op.data; m1.byteenable = op.be;
        end
    endtask

    task automatic do_op(input op_t op);
        int          ncyc;
        bit          done;
        logic [31:0] e;
        @(posedge clk); #1;
        drive(op.m, op, 1'b1);
        if (!op.wr || op.both) sb[op.m].push_back(op.exp);
        ncyc = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (grant == ((op.m == 0) ? 2'b01 : 2'b10)) ncyc++;
            if (!wreq(op.m)) begin
                done = 1'b1;
                check("grant_cycles", 32'(ncyc), 32'(op.stall + 1));
                check("other_wait", 32'(wreq(1 - op.m)), 32'd1);
                check("other_rdata", rdata(1 - op.m), 32'h0);
                if (op.both) check("rw_excl", 32'(s.write), 32'd0);
                if (!op.wr || op.both) begin
                    e = sb[op.m].pop_front();
                    check("rdata", rdata(op.m), e);
                end
            end
        end
        if (!done) begin
            total++;
            $display("FAIL op_timeout: m%0d got no completion, want one within 100 cycles", op.m);
        end
    endtask

    task automatic run_m(input int m);
        op_t op;
        while (opq[m].size() > 0) begin
            op = opq[m].pop_front();
            do_op(op);
        end
        @(posedge clk); #1;
        drive(m, op, 1'b0);
    endtask

    task automatic check_order(input string nm, input int exp[$]);
        check({nm, "_count"}, 32'(gq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < gq.size(); i++)
            check(nm, 32'(gq[i]), 32'(exp[i]));
    endtask

    function automatic op_t mk(int m, bit wr, bit both, logic [31:0] off, logic [31:0] data,
                               logic [3:0] be, int stall, logic [31:0] exp);
        op_t o;
        o.m = m; o.wr = wr; o.both = both; o.addr = MEM_RESET_VECTOR + off;
        o.data = data; o.be = be; o.stall = stall; o.exp = exp;
        return o;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        op_t vec[7];
        op_t z;
        int  eo[$];

        vec[0] = mk(0, 0, 0, 32'h00, 32'h0,        4'hF,   2, 32'h10000000);
        vec[1] = mk(1, 0, 0, 32'h10, 32'h0,        4'hF,   0, 32'hDEADBEEF);
        vec[2] = mk(1, 1, 0, 32'h20, 32'h11223344, 4'hF,   1, 32'h0);
        vec[3] = mk(1, 1, 0, 32'h20, 32'h0000AB00, 4'b0010, 0, 32'h0);
        vec[4] = mk(0, 0, 0, 32'h20, 32'h0,        4'hF,   0, 32'h1122AB44);
        vec[5] = mk(0, 0, 1, 32'h04, 32'hFFFFFFFF, 4'hF,   1, 32'h10000001);
        vec[6] = mk(1, 0, 0, 32'h04, 32'h0,        4'hF,   0, 32'h10000001);

        z = mk(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        drive(0, z, 1'b0);
        drive(1, z, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_timeout", 32'(timeout_error), 32'd0);
        check("rst_s_read", 32'(s.read), 32'd0);
        check("rst_s_write", 32'(s.write), 32'd0);
        check("rst_m0_wait", 32'(m0.waitrequest), 32'd1);
        check("rst_m1_wait", 32'(m1.waitrequest), 32'd1);

        // Simultaneous requests straight after reset.
        stall_cfg = 0;
        gq.delete(); gcyc.delete();
        opq[0].push_back(mk(0, 0, 0, 32'h04, 32'h0, 4'hF, 0, 32'h10000001));
        opq[1].push_back(mk(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0));
        fork
            run_m(0);
            run_m(1);
        join
`ifdef MEM_BUS_ARBITER_RR_EN
        eo = '{0, 1};
`else
        eo = '{1, 0};
`endif
        check_order("tie_order", eo);

        for (int i = 0; i < 7; i++) begin
            stall_cfg = vec[i].stall;
            opq[vec[i].m].push_back(vec[i]);
            run_m(vec[i].m);
        end

        // Both masters back-to-back with a zero-wait slave.
        stall_cfg = 0;
        gq.delete(); gcyc.delete();
        for (int i = 1; i <= 3; i++) begin
            opq[0].push_back(mk(0, 0, 0, 32'(4 * i), 32'h0, 4'hF, 0, 32'h10000000 | i));
            opq[1].push_back(mk(1, 0, 0, 32'(4 * (i + 4)), 32'h0, 4'hF, 0, 32'h10000000 | (i + 4)));
        end
        fork
            run_m(0);
            run_m(1);
        join
`ifdef MEM_BUS_ARBITER_RR_EN
        eo = '{0, 1, 0, 1, 0, 1};
`else
        eo = '{1, 1, 1, 0, 0, 0};
`endif
        check_order("burst_order", eo);
        for (int i = 1; i < gcyc.size(); i++)
            check("burst_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);

        // Slave never answers: abort after TO stalled grant cycles.
        stall_forever = 1'b1;
        @(posedge clk); #1;
        drive(0, mk(0, 0, 0, 32'h0, 32'h0, 4'hF, 0, 32'h0), 1'b1);
        @(negedge clk);
        check("wd_req_cycle_grant", 32'(grant), 32'd0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            check("wd_grant", 32'(grant), 32'd1);
            check("wd_flag_low", 32'(timeout_error), 32'd0);
        end
        @(negedge clk);
        check("wd_abort_grant", 32'(grant), 32'd0);
        check("wd_flag", 32'(timeout_error), 32'd1);
        check("wd_m0_wait", 32'(m0.waitrequest), 32'd1);
        @(posedge clk); #1;
        drive(0, z, 1'b0);
        repeat (3) @(negedge clk);
        check("wd_flag_sticky", 32'(timeout_error), 32'd1);
        check("wd_idle_grant", 32'(grant), 32'd0);

        // Reset in the middle of a stalled m0 grant.
        @(posedge clk); #1;
        drive(0, mk(0, 0, 0, 32'h0, 32'h0, 4'hF, 0, 32'h0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("rstmid_grant_before", 32'(grant), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_grant", 32'(grant), 32'd0);
        check("rstmid_s_read", 32'(s.read), 32'd0);
        check("rstmid_flag", 32'(timeout_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, z, 1'b0);
        stall_forever = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
